// File: rtl/camera_frame_grabber.sv
// Single-shot camera frame grabber: syncs the parallel bus and captures one framed image per arm.
// Latency pin->pixel_data_out is SYNC_STAGES+2 cycles; no backpressure, the camera cannot be stalled.
module camera_frame_grabber #(
  parameter int PIX_W       = 12,
  parameter int SYNC_STAGES = 3,
  parameter int LINE_W      = 11,
  parameter int EXP_LINES   = 0,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              sysClk,
  input  logic              rst,
  input  logic              arm,
  input  logic [PIX_W-1:0]  pixel_data_in,
  input  logic              FV,
  input  logic              LV,
  input  logic              Strobe,
  output logic [PIX_W-1:0]  pixel_data_out,
  output logic              valid_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              eof_out,
  output logic [LINE_W-1:0] line_count,
  output logic              busy,
  output logic              strobe_seen,
  output logic              frame_done,
  output logic              img_cap_fail_flag
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                 state;
  logic [PIX_W-1:0]       pix_sr [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fv_sr;
  logic [SYNC_STAGES-1:0] lv_sr;
  logic [SYNC_STAGES-1:0] stb_sr;
  logic [PIX_W-1:0]       pix_s;
  logic                   fv_s;
  logic                   lv_s;
  logic                   stb_s;
  logic                   fv_d;
  logic [TO_W-1:0]        tcnt;
  logic [PIX_W-1:0]       hold_pix;
  logic                   hold_vld;
  logic                   hold_sof;
  logic                   sof_pend;
  logic                   fv_rise;
  logic                   fv_fall;
  logic                   line_act;
  logic                   timeout;
  logic                   load;
  logic                   eol_now;
  logic                   abort;

  // All bus signals see the same number of stages so pixel, LV and FV stay aligned.
  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      fv_sr  <= '0;
      lv_sr  <= '0;
      stb_sr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) pix_sr[i] <= '0;
    end else begin
      pix_sr[0] <= pixel_data_in;
      fv_sr[0]  <= FV;
      lv_sr[0]  <= LV;
      stb_sr[0] <= Strobe;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pix_sr[i] <= pix_sr[i-1];
        fv_sr[i]  <= fv_sr[i-1];
        lv_sr[i]  <= lv_sr[i-1];
        stb_sr[i] <= stb_sr[i-1];
      end
    end
  end

  assign pix_s    = pix_sr[SYNC_STAGES-1];
  assign fv_s     = fv_sr[SYNC_STAGES-1];
  assign lv_s     = lv_sr[SYNC_STAGES-1];
  assign stb_s    = stb_sr[SYNC_STAGES-1];
  assign fv_rise  = fv_s & ~fv_d;
  assign fv_fall  = ~fv_s & fv_d;
  assign line_act = fv_s & lv_s;
  assign timeout  = (tcnt == TO_W'(TIMEOUT_CYC - 1));
  // A pixel coinciding with the FV rise is already part of the frame; timeout beats the rise.
  assign load     = line_act & ((state == CAPTURE) | ((state == ARMED) & fv_rise & ~timeout));
  assign eol_now  = hold_vld & ~line_act;
  assign abort    = (state == CAPTURE) & timeout & ~fv_fall;
  assign busy     = (state != IDLE);

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      fv_d              <= 1'b0;
      tcnt              <= '0;
      hold_pix          <= '0;
      hold_vld          <= 1'b0;
      hold_sof          <= 1'b0;
      sof_pend          <= 1'b0;
      pixel_data_out    <= '0;
      valid_out         <= 1'b0;
      sof_out           <= 1'b0;
      eol_out           <= 1'b0;
      eof_out           <= 1'b0;
      line_count        <= '0;
      strobe_seen       <= 1'b0;
      frame_done        <= 1'b0;
      img_cap_fail_flag <= 1'b0;
    end else begin
      fv_d              <= fv_s;
      frame_done        <= 1'b0;
      img_cap_fail_flag <= 1'b0;
      eof_out           <= (state == DONE);

      hold_vld <= load & ~abort;
      hold_pix <= (load & ~abort) ? pix_s : '0;
      hold_sof <= load & ~abort & sof_pend;
      if (load) sof_pend <= 1'b0;

      // Output stage: eol is decided here, once the following synced sample is visible.
      valid_out      <= hold_vld & ~abort;
      pixel_data_out <= abort ? '0 : hold_pix;
      sof_out        <= hold_sof & ~abort;
      eol_out        <= eol_now & ~abort;

      if ((state == CAPTURE) && eol_now && !abort && (line_count != {LINE_W{1'b1}}))
        line_count <= line_count + 1'b1;
      if ((state != IDLE) && stb_s) strobe_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (arm) begin
            state       <= ARMED;
            line_count  <= '0;
            strobe_seen <= 1'b0;
            tcnt        <= '0;
            sof_pend    <= 1'b1;
          end
        end
        ARMED: begin
          tcnt <= tcnt + 1'b1;
          if (timeout) begin
            img_cap_fail_flag <= 1'b1;
            state             <= IDLE;
          end else if (fv_rise) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          tcnt <= tcnt + 1'b1;
          if (fv_fall) begin
            state <= DONE;
          end else if (timeout) begin
            img_cap_fail_flag <= 1'b1;
            state             <= IDLE;
          end
        end
        DONE: begin
          if ((EXP_LINES != 0) && (line_count != LINE_W'(EXP_LINES)))
            img_cap_fail_flag <= 1'b1;
          else
            frame_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_frame_grabber.sv
// Bench for camera_frame_grabber: three instances share the camera pins (defaults, 1-stage with
// a 4-line size check, 50-cycle timeout); a pixel scoreboard per capturing instance.
module tb_camera_frame_grabber;

  localparam int PIX_W  = 12;
  localparam int LINE_W = 11;
  typedef logic [PIX_W+1:0] exp_t;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic             rst = 1'b1;
  logic             arm_a = 1'b0, arm_b = 1'b0, arm_c = 1'b0;
  logic [PIX_W-1:0] pix_in = '0;
  logic             fv = 1'b0, lv = 1'b0, strobe = 1'b0;
  logic [PIX_W-1:0] pix_ctr = '0;
  int               cyc = 0;

  always @(posedge sysClk) cyc <= cyc + 1;

  logic [PIX_W-1:0]  a_pix, b_pix, c_pix;
  logic              a_vld, a_sof, a_eol, a_eof, a_busy, a_stb, a_done, a_fail;
  logic              b_vld, b_sof, b_eol, b_eof, b_busy, b_stb, b_done, b_fail;
  logic              c_vld, c_sof, c_eol, c_eof, c_busy, c_stb, c_done, c_fail;
  logic [LINE_W-1:0] a_lc, b_lc, c_lc;

  camera_frame_grabber u_a (
    .sysClk(sysClk), .rst(rst), .arm(arm_a), .pixel_data_in(pix_in), .FV(fv), .LV(lv),
    .Strobe(strobe), .pixel_data_out(a_pix), .valid_out(a_vld), .sof_out(a_sof),
    .eol_out(a_eol), .eof_out(a_eof), .line_count(a_lc), .busy(a_busy),
    .strobe_seen(a_stb), .frame_done(a_done), .img_cap_fail_flag(a_fail));

  camera_frame_grabber #(.SYNC_STAGES(1), .EXP_LINES(4)) u_b (
    .sysClk(sysClk), .rst(rst), .arm(arm_b), .pixel_data_in(pix_in), .FV(fv), .LV(lv),
    .Strobe(strobe), .pixel_data_out(b_pix), .valid_out(b_vld), .sof_out(b_sof),
    .eol_out(b_eol), .eof_out(b_eof), .line_count(b_lc), .busy(b_busy),
    .strobe_seen(b_stb), .frame_done(b_done), .img_cap_fail_flag(b_fail));

  camera_frame_grabber #(.TIMEOUT_CYC(50)) u_c (
    .sysClk(sysClk), .rst(rst), .arm(arm_c), .pixel_data_in(pix_in), .FV(fv), .LV(lv),
    .Strobe(strobe), .pixel_data_out(c_pix), .valid_out(c_vld), .sof_out(c_sof),
    .eol_out(c_eol), .eof_out(c_eof), .line_count(c_lc), .busy(c_busy),
    .strobe_seen(c_stb), .frame_done(c_done), .img_cap_fail_flag(c_fail));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  exp_t qa[$], qb[$];
  int   ta[$], tb_q[$];
  int   a_nvld, a_nsof, a_neol, a_neof, a_ndone, a_nfail;
  int   b_nvld, b_nsof, b_neol, b_neof, b_ndone, b_nfail;

  always @(negedge sysClk) begin
    if (!rst) begin
      if (a_vld) begin
        a_nvld++;
        if (qa.size() == 0) check("a_extra_pixel", 32'(a_vld), 0);
        else begin
          exp_t e;
          int   t;
          e = qa.pop_front();
          t = ta.pop_front();
          check("a_pixel", 32'({a_sof, a_eol, a_pix}), 32'(e));
          check("a_latency", cyc - t, 5);
        end
      end else check("a_pix_idle", 32'(a_pix), 0);
      if (a_sof)  a_nsof++;
      if (a_eol)  a_neol++;
      if (a_done) a_ndone++;
      if (a_fail) a_nfail++;
      if (a_eof) begin
        a_neof++;
        check("a_eof_alone", 32'({a_eol, a_vld}), 0);
      end
    end
  end

  always @(negedge sysClk) begin
    if (!rst) begin
      if (b_vld) begin
        b_nvld++;
        if (qb.size() == 0) check("b_extra_pixel", 32'(b_vld), 0);
        else begin
          exp_t e;
          int   t;
          e = qb.pop_front();
          t = tb_q.pop_front();
          check("b_pixel", 32'({b_sof, b_eol, b_pix}), 32'(e));
          check("b_latency", cyc - t, 3);
        end
      end else check("b_pix_idle", 32'(b_pix), 0);
      if (b_sof)  b_nsof++;
      if (b_eol)  b_neol++;
      if (b_done) b_ndone++;
      if (b_fail) b_nfail++;
      if (b_eof) begin
        b_neof++;
        check("b_eof_alone", 32'({b_eol, b_vld}), 0);
      end
    end
  end

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic clear_counts();
    a_nvld = 0; a_nsof = 0; a_neol = 0; a_neof = 0; a_ndone = 0; a_nfail = 0;
    b_nvld = 0; b_nsof = 0; b_neol = 0; b_neof = 0; b_ndone = 0; b_nfail = 0;
  endtask

  task automatic pulse_arm(input logic ia, input logic ib);
    step(); arm_a = ia; arm_b = ib;
    step(); arm_a = 1'b0; arm_b = 1'b0;
  endtask

  task automatic send_line(input int npx, input logic ca, input logic cb, input logic first);
    for (int i = 0; i < npx; i++) begin
      logic s, e;
      step();
      lv     = 1'b1;
      pix_in = pix_ctr;
      s      = first && (i == 0);
      e      = (i == npx - 1);
      if (ca) begin qa.push_back({s, e, pix_ctr}); ta.push_back(cyc); end
      if (cb) begin qb.push_back({s, e, pix_ctr}); tb_q.push_back(cyc); end
      pix_ctr++;
    end
    step(); lv = 1'b0; pix_in = PIX_W'($urandom);
    step(); pix_in = PIX_W'($urandom);
  endtask

  task automatic send_frame(input int nl, input int npx, input logic ca, input logic cb);
    step(); fv = 1'b1; strobe = 1'b1;
    step(); strobe = 1'b0;
    for (int l = 0; l < nl; l++) send_line(npx, ca, cb, l == 0);
    step(); fv = 1'b0;
    repeat (4) step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy || c_busy) && n < 500) begin
      @(negedge sysClk);
      n++;
    end
    check("wait_idle", 32'({a_busy, b_busy, c_busy}), 0);
    repeat (2) @(negedge sysClk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    clear_counts();
    repeat (3) step();
    check("rst_valid", 32'({a_vld, b_vld, c_vld}), 0);
    check("rst_busy", 32'({a_busy, b_busy, c_busy}), 0);
    check("rst_line_count", 32'(a_lc), 0);
    check("rst_flags", 32'({a_done, a_fail, a_eof, a_stb, c_fail}), 0);
    rst = 1'b0;
    repeat (3) step();

    // 4 lines x 6 px, both A and B capture; B expects 4 lines
    clear_counts();
    pulse_arm(1'b1, 1'b1);
    send_frame(4, 6, 1'b1, 1'b1);
    wait_idle();
    check("t1_a_valid_count", a_nvld, 24);
    check("t1_a_sof_count", a_nsof, 1);
    check("t1_a_eol_count", a_neol, 4);
    check("t1_a_eof_count", a_neof, 1);
    check("t1_a_done", a_ndone, 1);
    check("t1_a_fail", a_nfail, 0);
    check("t1_a_line_count", 32'(a_lc), 4);
    check("t1_a_strobe_seen", 32'(a_stb), 1);
    check("t1_b_valid_count", b_nvld, 24);
    check("t1_b_done", b_ndone, 1);
    check("t1_b_fail", b_nfail, 0);
    check("t1_b_line_count", 32'(b_lc), 4);
    check("t1_queues", qa.size() + qb.size(), 0);

    // arm A in the middle of a frame; that frame is skipped, the next one captured
    clear_counts();
    step(); fv = 1'b1;
    send_line(5, 1'b0, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b0);
    pulse_arm(1'b1, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b0);
    step(); fv = 1'b0;
    repeat (3) step();
    send_frame(3, 5, 1'b1, 1'b0);
    wait_idle();
    check("t2_a_valid_count", a_nvld, 15);
    check("t2_a_sof_count", a_nsof, 1);
    check("t2_a_eof_count", a_neof, 1);
    check("t2_a_done", a_ndone, 1);
    check("t2_a_line_count", 32'(a_lc), 3);
    check("t2_b_valid_count", b_nvld, 0);
    check("t2_queues", qa.size(), 0);

    // B expects 4 lines, gets 3
    clear_counts();
    pulse_arm(1'b0, 1'b1);
    send_frame(3, 4, 1'b0, 1'b1);
    wait_idle();
    check("t3_b_valid_count", b_nvld, 12);
    check("t3_b_eof_count", b_neof, 1);
    check("t3_b_fail", b_nfail, 1);
    check("t3_b_done", b_ndone, 0);
    check("t3_b_line_count", 32'(b_lc), 3);
    check("t3_a_valid_count", a_nvld, 0);
    check("t3_queues", qb.size(), 0);

    // C has a 50-cycle timeout and FV never rises
    begin
      int t_arm;
      int n;
      logic got;
      step(); arm_c = 1'b1; t_arm = cyc + 1;
      step(); arm_c = 1'b0;
      @(negedge sysClk);
      check("t4_c_busy_armed", 32'(c_busy), 1);
      n = 0; got = 1'b0;
      while (n < 200 && !got) begin
        @(negedge sysClk);
        if (c_fail) got = 1'b1;
        else n++;
      end
      check("t4_c_timeout_cycles", cyc - t_arm, 50);
      check("t4_c_busy_after", 32'(c_busy), 0);
      check("t4_c_strobe_seen", 32'(c_stb), 0);
      @(negedge sysClk);
      check("t4_c_fail_pulse", 32'({c_fail, c_done}), 0);
    end

    // reset in the middle of a line, then a clean capture
    clear_counts();
    pulse_arm(1'b1, 1'b0);
    step(); fv = 1'b1;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      step();
      lv = 1'b1;
      pix_in = pix_ctr;
      qa.push_back({(i == 0), 1'b0, pix_ctr});
      ta.push_back(cyc);
      pix_ctr++;
    end
    step();
    check("t5_valid_before_rst", 32'(a_vld), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(a_vld), 0);
    check("t5_rst_pix", 32'(a_pix), 0);
    check("t5_rst_busy", 32'(a_busy), 0);
    qa.delete();
    ta.delete();
    lv = 1'b0; fv = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    check("t5_no_end_flags", a_neof + a_ndone + a_nfail, 0);
    clear_counts();
    pulse_arm(1'b1, 1'b0);
    send_frame(2, 6, 1'b1, 1'b0);
    wait_idle();
    check("t5_a_valid_count", a_nvld, 12);
    check("t5_a_sof_count", a_nsof, 1);
    check("t5_a_done", a_ndone, 1);
    check("t5_a_line_count", 32'(a_lc), 2);

    // full 12-bit ramp through both sync depths
    clear_counts();
    pix_ctr = '0;
    pulse_arm(1'b1, 1'b1);
    send_frame(64, 64, 1'b1, 1'b1);
    wait_idle();
    check("t6_a_valid_count", a_nvld, 4096);
    check("t6_a_done", a_ndone, 1);
    check("t6_a_line_count", 32'(a_lc), 64);
    check("t6_b_valid_count", b_nvld, 4096);
    check("t6_b_fail", b_nfail, 1);
    check("t6_b_done", b_ndone, 0);
    check("t6_queues", qa.size() + qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
